// File: rtl/snn_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | snn_pkg : shared FSM state type and default sizes for the SNN path |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
package snn_pkg;

   localparam int DEF_WIDTH   = 8;
   localparam int DEF_NEURONS = 3;

   typedef enum logic [1:0] {
      ST_SEND    = 2'd0,
      ST_COLLECT = 2'd1,
      ST_EMIT    = 2'd2,
      ST_DONE    = 2'd3
   } state_t;

endpackage
`default_nettype wire

// File: rtl/mem_spike_join.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mem_spike_join : accepts membrane and spike channels only jointly  |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
module mem_spike_join (
   input  logic active,
   input  logic mem_out_valid,
   input  logic spike_valid,
   output logic mem_out_ready,
   output logic spike_ready,
   output logic accept
);

   // A lone valid on either channel is left pending rather than consumed.
   assign accept        = active & mem_out_valid & spike_valid;
   assign mem_out_ready = accept;
   assign spike_ready   = accept;

endmodule
`default_nettype wire

// File: rtl/mem_spike_collector.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mem_spike_collector : streams stored membranes to the adder, packs |
// | returned spikes per timestep. rev 1.0                              |
// +--------------------------------------------------------------------+
module mem_spike_collector
   import snn_pkg::*;
#(
   parameter int WIDTH   = DEF_WIDTH,
   parameter int NEURONS = DEF_NEURONS,
   parameter int NUM_TS  = 4
) (
   input  logic                        clk,
   input  logic                        rst_n,
   output logic [WIDTH-1:0]            mem_in_data,
   output logic                        mem_in_valid,
   input  logic                        mem_in_ready,
   input  logic [WIDTH-1:0]            mem_out_data,
   input  logic                        mem_out_valid,
   output logic                        mem_out_ready,
   input  logic                        spike_in,
   input  logic                        spike_valid,
   output logic                        spike_ready,
   output logic [NEURONS-1:0]          spike_vec,
   output logic                        spike_vec_valid,
   input  logic                        spike_vec_ready,
   output logic [$clog2(NUM_TS+1)-1:0] ts_count,
   output logic                        done
);

   localparam int PW = (NEURONS > 1) ? $clog2(NEURONS) : 1;
   localparam int TW = $clog2(NUM_TS + 1);
   localparam logic [PW-1:0] PTR_LAST = PW'(NEURONS - 1);
   localparam logic [TW-1:0] TS_LAST  = TW'(NUM_TS - 1);

   state_t             state;
   state_t             state_nx;
   logic [PW-1:0]      ptr;
   logic [WIDTH-1:0]   mem_reg [NEURONS];
   logic [NEURONS-1:0] spk_reg;
   logic               in_collect;
   logic               pair_acc;
   logic               in_xfer;
   logic               vec_xfer;

   // Valids are gated by rst_n so every handshake output drops the instant reset asserts.
   assign mem_in_valid    = rst_n && (state == ST_SEND);
   assign in_collect      = rst_n && (state == ST_COLLECT);
   assign spike_vec_valid = rst_n && (state == ST_EMIT);
   assign mem_in_data     = mem_reg[ptr];
   assign spike_vec       = spk_reg;
   assign in_xfer         = mem_in_valid & mem_in_ready;
   assign vec_xfer        = spike_vec_valid & spike_vec_ready;

   mem_spike_join u_join (
      .active        (in_collect),
      .mem_out_valid (mem_out_valid),
      .spike_valid   (spike_valid),
      .mem_out_ready (mem_out_ready),
      .spike_ready   (spike_ready),
      .accept        (pair_acc)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_SEND;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      done     = 1'b0;
      case (state)
         ST_SEND: begin
            if (in_xfer && (ptr == PTR_LAST)) state_nx = ST_COLLECT;
         end
         ST_COLLECT: begin
            if (pair_acc && (ptr == PTR_LAST)) state_nx = ST_EMIT;
         end
         ST_EMIT: begin
            if (vec_xfer) state_nx = (ts_count == TS_LAST) ? ST_DONE : ST_SEND;
         end
         ST_DONE: begin
            done = 1'b1;
         end
         default: state_nx = ST_SEND;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr      <= '0;
         ts_count <= '0;
         spk_reg  <= '0;
         for (int i = 0; i < NEURONS; i++) mem_reg[i] <= '0;
      end else begin
         case (state)
            ST_SEND: begin
               if (in_xfer) ptr <= (ptr == PTR_LAST) ? '0 : ptr + 1'b1;
            end
            ST_COLLECT: begin
               if (pair_acc) begin
                  mem_reg[ptr] <= mem_out_data;
                  spk_reg[ptr] <= spike_in;
                  ptr          <= (ptr == PTR_LAST) ? '0 : ptr + 1'b1;
               end
            end
            ST_EMIT: begin
               if (vec_xfer) ts_count <= ts_count + 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mem_spike_collector.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_mem_spike_collector : randomized self-checking bench            |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_mem_spike_collector;

   localparam int W  = 8;
   localparam int N  = 3;
   localparam int T  = 4;
   localparam int TW = $clog2(T + 1);

   logic          clk = 1'b0;
   logic          rst_n;
   logic [W-1:0]  mem_in_data;
   logic          mem_in_valid;
   logic          mem_in_ready;
   logic [W-1:0]  mem_out_data;
   logic          mem_out_valid;
   logic          mem_out_ready;
   logic          spike_in;
   logic          spike_valid;
   logic          spike_ready;
   logic [N-1:0]  spike_vec;
   logic          spike_vec_valid;
   logic          spike_vec_ready;
   logic [TW-1:0] ts_count;
   logic          done;

   int total = 0;
   int bad   = 0;

   // Reference model: what each neuron slot should hold and how many timesteps finished.
   logic [W-1:0] model_mem [N];
   logic         model_spk [N];
   int           model_ts;
   logic [W-1:0] col_mem [N];
   logic         col_spk [N];

   always #5 clk = ~clk;

   mem_spike_collector #(.WIDTH(W), .NEURONS(N), .NUM_TS(T)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .mem_in_data     (mem_in_data),
      .mem_in_valid    (mem_in_valid),
      .mem_in_ready    (mem_in_ready),
      .mem_out_data    (mem_out_data),
      .mem_out_valid   (mem_out_valid),
      .mem_out_ready   (mem_out_ready),
      .spike_in        (spike_in),
      .spike_valid     (spike_valid),
      .spike_ready     (spike_ready),
      .spike_vec       (spike_vec),
      .spike_vec_valid (spike_vec_valid),
      .spike_vec_ready (spike_vec_ready),
      .ts_count        (ts_count),
      .done            (done)
   );

   function automatic logic [N-1:0] exp_vec();
      logic [N-1:0] v;
      for (int k = 0; k < N; k++) v[k] = model_spk[k];
      return v;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < N; k++) begin
         model_mem[k] = '0;
         model_spk[k] = 1'b0;
      end
      model_ts = 0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      mem_in_ready = 0; mem_out_valid = 0; spike_valid = 0; spike_vec_ready = 0;
      mem_out_data = '0; spike_in = 0;
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk); #1;
      total++;
      if (mem_in_valid !== 1'b0 || mem_in_data !== '0 || spike_vec !== '0 ||
          ts_count !== '0 || done !== 1'b0 || spike_vec_valid !== 1'b0)
         begin bad++; $display("FAIL reset_state valid=%b data=%0d vec=%b ts=%0d done=%b exp all zero",
                               mem_in_valid, mem_in_data, spike_vec, ts_count, done); end
      rst_n = 1'b1; #1;
      total++;
      if (mem_in_valid !== 1'b1 || mem_in_data !== '0)
         begin bad++; $display("FAIL first_valid valid=%b data=%0d exp valid=1 data=0", mem_in_valid, mem_in_data); end
   endtask

   task automatic send_phase(input bit stall_en);
      for (int k = 0; k < N; k++) begin
         int stalls = stall_en ? int'($urandom_range(0, 2)) : 0;
         for (int s = 0; s < stalls; s++) begin
            @(negedge clk);
            mem_in_ready  = 1'b0;
            mem_out_valid = 1'($urandom);
            spike_valid   = 1'($urandom);
            #1;
            total++;
            if (mem_in_valid !== 1'b1 || mem_in_data !== model_mem[k])
               begin bad++; $display("FAIL send_hold k=%0d valid=%b data=%0d exp data=%0d",
                                     k, mem_in_valid, mem_in_data, model_mem[k]); end
            total++;
            if (mem_out_ready !== 1'b0 || spike_ready !== 1'b0)
               begin bad++; $display("FAIL send_no_collect mo_rdy=%b sp_rdy=%b exp 0", mem_out_ready, spike_ready); end
         end
         @(negedge clk);
         mem_in_ready = 1'b1; mem_out_valid = 0; spike_valid = 0;
         #1;
         total++;
         if (mem_in_valid !== 1'b1 || mem_in_data !== model_mem[k])
            begin bad++; $display("FAIL send_data k=%0d valid=%b data=%0d exp data=%0d",
                                  k, mem_in_valid, mem_in_data, model_mem[k]); end
         @(posedge clk);
      end
      @(negedge clk);
      mem_in_ready = 1'b0;
      #1;
      total++;
      if (mem_in_valid !== 1'b0)
         begin bad++; $display("FAIL send_exit valid=%b exp 0", mem_in_valid); end
   endtask

   // Accepts n_acc pairs; slot lone_idx first sees lone_cycles of membrane-only valid.
   task automatic collect_phase(input int n_acc, input int lone_idx, input int lone_cycles);
      for (int k = 0; k < n_acc; k++) begin
         int lone = (k == lone_idx) ? lone_cycles : int'($urandom_range(0, 2));
         for (int s = 0; s < lone; s++) begin
            @(negedge clk);
            mem_out_valid = (k == lone_idx) ? 1'b1 : 1'($urandom);
            spike_valid   = ~mem_out_valid;
            mem_out_data  = W'($urandom);
            spike_in      = 1'($urandom);
            #1;
            total++;
            if (mem_out_ready !== 1'b0 || spike_ready !== 1'b0 || mem_in_valid !== 1'b0)
               begin bad++; $display("FAIL lone_valid k=%0d mo_rdy=%b sp_rdy=%b mi_vld=%b exp 0",
                                     k, mem_out_ready, spike_ready, mem_in_valid); end
         end
         @(negedge clk);
         mem_out_valid = 1'b1; spike_valid = 1'b1;
         mem_out_data  = col_mem[k]; spike_in = col_spk[k];
         #1;
         total++;
         if (mem_out_ready !== 1'b1 || spike_ready !== 1'b1)
            begin bad++; $display("FAIL joint_accept k=%0d mo_rdy=%b sp_rdy=%b exp 1", k, mem_out_ready, spike_ready); end
         @(posedge clk);
         model_mem[k] = col_mem[k];
         model_spk[k] = col_spk[k];
      end
      @(negedge clk);
      mem_out_valid = 1'b0; spike_valid = 1'b0;
   endtask

   task automatic emit_phase(input int stall);
      logic [N-1:0] ev = exp_vec();
      for (int s = 0; s < stall; s++) begin
         spike_vec_ready = 1'b0; #1;
         total++;
         if (spike_vec_valid !== 1'b1 || spike_vec !== ev || ts_count !== TW'(model_ts))
            begin bad++; $display("FAIL emit_hold valid=%b vec=%b ts=%0d exp vec=%b ts=%0d",
                                  spike_vec_valid, spike_vec, ts_count, ev, model_ts); end
         @(negedge clk);
      end
      spike_vec_ready = 1'b1; #1;
      total++;
      if (spike_vec_valid !== 1'b1 || spike_vec !== ev)
         begin bad++; $display("FAIL emit_vec valid=%b vec=%b exp vec=%b", spike_vec_valid, spike_vec, ev); end
      @(posedge clk);
      model_ts++;
      @(negedge clk);
      spike_vec_ready = 1'b0; #1;
      total++;
      if (ts_count !== TW'(model_ts) || spike_vec_valid !== 1'b0)
         begin bad++; $display("FAIL emit_count ts=%0d vld=%b exp ts=%0d vld=0", ts_count, spike_vec_valid, model_ts); end
      total++;
      if (model_ts == T) begin
         if (done !== 1'b1) begin bad++; $display("FAIL done_flag done=%b exp 1", done); end
      end else if (mem_in_valid !== 1'b1 || done !== 1'b0) begin
         bad++; $display("FAIL emit_next mi_vld=%b done=%b exp 1/0", mem_in_valid, done);
      end
   endtask

   task automatic randomize_batch();
      for (int k = 0; k < N; k++) begin
         col_mem[k] = W'($urandom);
         col_spk[k] = 1'($urandom);
      end
   endtask

   task automatic test_first_send();
      send_phase(1'b0);
   endtask

   task automatic test_collect_join();
      col_mem[0] = 8'd20; col_spk[0] = 1'b0;
      col_mem[1] = 8'd70; col_spk[1] = 1'b1;
      col_mem[2] = 8'd5;  col_spk[2] = 1'b0;
      collect_phase(N, 1, 5);
   endtask

   task automatic test_emit_stall();
      total++;
      if (spike_vec !== 3'b010)
         begin bad++; $display("FAIL packed_vec vec=%b exp 010", spike_vec); end
      emit_phase(4);
   endtask

   task automatic test_timesteps();
      for (int t = 1; t < T; t++) begin
         send_phase(1'b1);
         randomize_batch();
         collect_phase(N, -1, 0);
         emit_phase(int'($urandom_range(0, 3)));
      end
   endtask

   task automatic test_done_ignore();
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         mem_in_ready = 1; mem_out_valid = 1; spike_valid = 1; spike_vec_ready = 1;
         mem_out_data = W'($urandom); spike_in = 1'($urandom);
         #1;
         total++;
         if (done !== 1'b1 || mem_in_valid !== 1'b0 || mem_out_ready !== 1'b0 ||
             spike_ready !== 1'b0 || spike_vec_valid !== 1'b0 || ts_count !== TW'(T))
            begin bad++; $display("FAIL done_idle done=%b mi=%b mo=%b sp=%b sv=%b ts=%0d exp 1/0/0/0/0/%0d",
                                  done, mem_in_valid, mem_out_ready, spike_ready, spike_vec_valid, ts_count, T); end
      end
      mem_in_ready = 0; mem_out_valid = 0; spike_valid = 0; spike_vec_ready = 0;
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      rst_n = 1'b0;
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      send_phase(1'b1);
      randomize_batch();
      collect_phase(2, -1, 0);
      mem_out_valid = 1; spike_valid = 1; mem_out_data = col_mem[2]; spike_in = 1'b1;
      rst_n = 1'b0;
      model_reset();
      #1;
      total++;
      if (mem_in_valid !== 1'b0 || mem_out_ready !== 1'b0 || spike_ready !== 1'b0 ||
          spike_vec_valid !== 1'b0 || spike_vec !== '0 || mem_in_data !== '0 ||
          ts_count !== '0 || done !== 1'b0)
         begin bad++; $display("FAIL reset_mid mi=%b mo=%b sp=%b sv=%b vec=%b data=%0d ts=%0d done=%b exp all 0",
                               mem_in_valid, mem_out_ready, spike_ready, spike_vec_valid,
                               spike_vec, mem_in_data, ts_count, done); end
      @(negedge clk);
      mem_out_valid = 0; spike_valid = 0;
      rst_n = 1'b1;
      send_phase(1'b0);
      randomize_batch();
      collect_phase(N, -1, 0);
      emit_phase(1);
   endtask

   initial begin
      test_reset();
      test_first_send();
      test_collect_join();
      test_emit_stall();
      test_timesteps();
      test_done_ignore();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/mem_spike_collector.md
MEM_SPIKE_COLLECTOR -- requirements
Module: mem_spike_collector

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning membrane potential width in bits.
REQ-002 SHALL have parameter NEURONS, default 3, meaning neurons per timestep batch.
REQ-003 SHALL have parameter NUM_TS, default 4, meaning timesteps to process before done.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port mem_in_data  output  WIDTH  stored membrane sent to the adder's membrane input.
REQ-007 SHALL have port mem_in_valid  output  1  mem_in_data valid.
REQ-008 SHALL have port mem_in_ready  input  1  adder accepts mem_in_data.
REQ-009 SHALL have port mem_out_data  input  WIDTH  updated membrane from the adder.
REQ-010 SHALL have port mem_out_valid  input  1  mem_out_data valid.
REQ-011 SHALL have port mem_out_ready  output  1  collector accepts mem_out_data.
REQ-012 SHALL have port spike_in  input  1  spike bit from the adder.
REQ-013 SHALL have port spike_valid  input  1  spike_in valid.
REQ-014 SHALL have port spike_ready  output  1  collector accepts spike_in.
REQ-015 SHALL have port spike_vec  output  NEURONS  packed spikes for the timestep; bit k = neuron k.
REQ-016 SHALL have port spike_vec_valid  output  1  spike_vec valid.
REQ-017 SHALL have port spike_vec_ready  input  1  downstream accepts spike_vec.
REQ-018 SHALL have port ts_count  output  $clog2(NUM_TS+1)  completed timesteps.
REQ-019 SHALL have port done  output  1  all NUM_TS timesteps complete.

Function
REQ-020 SHALL implement FSM states SEND, COLLECT, EMIT, DONE; a transfer occurs on a rising edge with valid and ready both high.
REQ-021 SEND: mem_in_valid=1, mem_in_data=mem_reg[ptr]; each transfer increments ptr; transfer with ptr==NEURONS-1 clears ptr and enters COLLECT.
REQ-022 COLLECT: mem_out_ready and spike_ready SHALL both equal (mem_out_valid AND spike_valid), so a pair is accepted only jointly; a lone valid on either channel SHALL NOT be consumed.
REQ-023 COLLECT accept: mem_reg[ptr]<=mem_out_data, spk_reg[ptr]<=spike_in, ptr++; accept with ptr==NEURONS-1 clears ptr and enters EMIT.
REQ-024 EMIT: spike_vec_valid=1, spike_vec=spk_reg; on transfer ts_count increments; next state DONE if new ts_count==NUM_TS, else SEND.
REQ-025 DONE: done=1, all valid/ready outputs 0, inputs ignored; exits only via reset.
REQ-026 Outputs mem_in_valid, mem_out_ready, spike_ready, spike_vec_valid SHALL be 0 outside their own state.
REQ-027 Valid outputs SHALL stay high with stable data until the transfer completes.
REQ-028 Membrane values SHALL be stored unmodified (no threshold/arithmetic); WIDTH bits, no wrap logic.
REQ-029 Latency: first mem_in_valid SHALL assert in the first cycle after reset release; each state change SHALL take effect the cycle after its final transfer.
REQ-030 SEND and COLLECT SHALL never overlap; mem_reg read/write hazards cannot occur.

Reset
REQ-031 rst_n low SHALL immediately force state SEND, ptr 0, ts_count 0, done 0, mem_reg all 0, spk_reg 0, spike_vec 0, mem_in_data 0.
REQ-032 Reset asserted mid-transfer SHALL abandon the timestep; no partial state survives.

Structure
REQ-033 Package snn_pkg SHALL hold the FSM state enum typedef and default WIDTH/NEURONS constants.
REQ-034 Sub-module mem_spike_join SHALL implement the two-channel joint-accept logic of REQ-022.

Verification
REQ-035 Reset, mem_in_ready=1: three mem_in transfers of 0,0,0 in consecutive cycles, then COLLECT.
REQ-036 Collect (20,0),(70,1),(5,0); next SEND emits 20,70,5; spike_vec=3'b010.
REQ-037 mem_out_valid=1 with spike_valid=0 for 5 cycles: no accept, ptr unchanged; spike_valid rises -> pair accepted that cycle.
REQ-038 spike_vec_ready=0 for 4 cycles in EMIT: spike_vec_valid and 3'b010 held stable, ts_count unchanged.
REQ-039 Run NUM_TS=4 timesteps: ts_count=4, done=1, further valids ignored.
REQ-040 rst_n low after second COLLECT accept: outputs zero instantly; next SEND emits 0,0,0.
